// File: rtl/axis_async_fifo_pkt_if.sv
// Stream bundle for the dual-clock packet FIFO: write-side beats, read-side beats and both load views.
// Latency: none, wires only.
// Backpressure: s_ready / m_ready carried as ordinary members; "slave" is the FIFO view, "master" the surroundings.
interface axis_async_fifo_pkt_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 7
);
  logic                  s_valid;
  logic                  s_ready;
  logic [WIDTH-1:0]      s_data;
  logic                  s_last;
  logic [DEPTH_BITS:0]   s_load;
  logic                  s_almost_full;
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;
  logic [DEPTH_BITS:0]   m_load;

  // FIFO side: consumes write beats, produces read beats
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, s_load, s_almost_full, m_valid, m_data, m_last, m_load
  );

  // producer/consumer side
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, s_load, s_almost_full, m_valid, m_data, m_last, m_load
  );
endinterface

// File: rtl/axis_async_fifo_pkt.sv
// Dual-clock AXI-Stream FIFO with TLAST, almost-full and first-word-fall-through output; all 2**DEPTH_BITS slots usable.
// Latency: 1 s_clk (gray register) + SYNC_STAGES m_clk + 1 m_clk (output register); freed slots return symmetrically.
// Backpressure: s_ready drops when full, output word held stable while m_valid & !m_ready.
// Optional packet mode: define AXIS_ASYNC_FIFO_PKT_EN to publish only whole packets (commit pointer on s_last).
module axis_async_fifo_pkt #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_BITS  = 7,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  m_clk,
  input  logic                  m_rst,
  axis_async_fifo_pkt_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int PW    = DEPTH_BITS + 1;   // pointer width including the wrap bit

  typedef logic [PW-1:0]  ptr_t;
  typedef logic [WIDTH:0] word_t;          // {last, data}

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Storage is written only from s_clk and read only for slots the read side has seen published,
  // so an unreset array with an asynchronous read port is safe.
  word_t mem [DEPTH];

  // ---------------------------------------------------------------- write side (s_clk)
  ptr_t  wr_bin;
  ptr_t  wr_gray_now;
  ptr_t  pub_bin;            // pointer made visible to the read side
  ptr_t  pub_gray;
  ptr_t  rd_gray_sync [SYNC_STAGES];
  ptr_t  rd_sync_bin;
  ptr_t  rd_sync_gray;
  logic  s_live;
  logic  full;
  logic  wr_en;
  logic [PW:0] free_cnt;

  // ---------------------------------------------------------------- read side (m_clk)
  ptr_t  rd_bin;             // index of the head word (the one in the output register when m_valid)
  ptr_t  rd_gray;
  ptr_t  head_bin;
  ptr_t  wr_gray_sync [SYNC_STAGES];
  ptr_t  wr_sync_bin;
  logic  m_valid_q;
  word_t out_q;
  logic  pop;
  logic  load;

  assign rd_sync_gray = rd_gray_sync[SYNC_STAGES-1];
  assign rd_sync_bin  = gray2bin(rd_sync_gray);
  assign wr_gray_now  = bin2gray(wr_bin);

  // Full when the write pointer is exactly one lap ahead of the synced read pointer: in gray code
  // that is the top two bits inverted and the rest equal. Uses the live write pointer so a beat
  // accepted this cycle is already counted; the synced read side is stale, so full may clear late.
  assign full = (wr_gray_now == {~rd_sync_gray[PW-1:PW-2], rd_sync_gray[PW-3:0]});

  // s_live keeps s_ready low during reset even though the pointers already read as empty.
  assign bus.s_ready = s_live & ~full;
  assign wr_en       = bus.s_valid & bus.s_ready;

  // Occupancy from the write side, including beats not yet committed in packet mode.
  assign bus.s_load        = wr_bin - rd_sync_bin;
  assign free_cnt          = (PW+1)'(DEPTH) - {1'b0, bus.s_load};
  assign bus.s_almost_full = (free_cnt <= (PW+1)'(AF_LEVEL));

  // write pointer and ready qualifier
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_bin <= '0;
      s_live <= 1'b0;
    end else begin
      s_live <= 1'b1;
      if (wr_en) begin
        wr_bin <= wr_bin + ptr_t'(1);
      end
    end
  end

  // store accepted beats together with their last flag
  always_ff @(posedge s_clk) begin
    if (wr_en) begin
      mem[wr_bin[DEPTH_BITS-1:0]] <= {bus.s_last, bus.s_data};
    end
  end

`ifdef AXIS_ASYNC_FIFO_PKT_EN
  ptr_t commit_bin;

  // commit pointer advances past a packet only when its last beat is accepted
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      commit_bin <= '0;
    end else if (wr_en && bus.s_last) begin
      commit_bin <= wr_bin + ptr_t'(1);
    end
  end

  assign pub_bin = commit_bin;
`else
  // every accepted beat is visible to the reader individually
  assign pub_bin = wr_bin;
`endif

  // registered gray copy of the published pointer: the only write-side value crossing domains
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      pub_gray <= '0;
    end else begin
      pub_gray <= bin2gray(pub_bin);
    end
  end

  // bring the reader's gray pointer into s_clk
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rd_gray_sync[i] <= '0;
      end
    end else begin
      rd_gray_sync[0] <= rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_gray_sync[i] <= rd_gray_sync[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- read side logic
  assign wr_sync_bin = gray2bin(wr_gray_sync[SYNC_STAGES-1]);

  // The output register is refilled whenever it is empty or its word is being taken. The head
  // pointer only moves on a handshake, so the held word keeps its slot reserved until consumed;
  // that keeps s_load/m_load within 0..DEPTH and full exact.
  assign pop      = m_valid_q & bus.m_ready;
  assign load     = ~m_valid_q | pop;
  assign head_bin = pop ? (rd_bin + ptr_t'(1)) : rd_bin;

  // FWFT output register and head pointer
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      rd_bin    <= '0;
      m_valid_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_bin <= head_bin;
      if (load) begin
        if (head_bin != wr_sync_bin) begin
          out_q     <= mem[head_bin[DEPTH_BITS-1:0]];
          m_valid_q <= 1'b1;
        end else begin
          m_valid_q <= 1'b0;
        end
      end
    end
  end

  // registered gray copy of the head pointer for the write side
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      rd_gray <= '0;
    end else begin
      rd_gray <= bin2gray(rd_bin);
    end
  end

  // bring the published write pointer into m_clk
  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wr_gray_sync[i] <= '0;
      end
    end else begin
      wr_gray_sync[0] <= pub_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wr_gray_sync[i] <= wr_gray_sync[i-1];
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = out_q[WIDTH-1:0];
  assign bus.m_last  = out_q[WIDTH];
  // counts the head word too, since rd_bin has not moved past it yet
  assign bus.m_load  = wr_sync_bin - rd_bin;

endmodule

// File: tb/tb_axis_async_fifo_pkt.sv
`timescale 1ns/1ps
module tb_axis_async_fifo_pkt;
  localparam int WIDTH = 8;
  localparam int DB    = 3;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int AF    = 4;

  logic s_clk = 1'b0;
  logic m_clk = 1'b0;
  logic s_rst = 1'b1;
  logic m_rst = 1'b1;
  realtime s_half = 5.0;
  realtime m_half = 13.5;

  always #(s_half) s_clk = ~s_clk;
  always #(m_half) m_clk = ~m_clk;

  axis_async_fifo_pkt_if #(.WIDTH(WIDTH), .DEPTH_BITS(DB)) bus ();

  axis_async_fifo_pkt #(
    .WIDTH(WIDTH), .DEPTH_BITS(DB), .SYNC_STAGES(SYNC), .AF_LEVEL(AF)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst), .m_clk(m_clk), .m_rst(m_rst), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int rx_cnt   = 0;
  logic [8:0] exp_q [$];   // reference model: beats in acceptance order, {last, data}
  realtime t_wr;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         exp_load;
    logic       exp_af;
    logic       exp_rdy;
  } fill_vec_t;
  fill_vec_t fill_tab [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string why);
    n_checks++;
    n_fails++;
    $display("FAIL %s: %s", name, why);
  endtask

  // one beat, waiting (bounded) for s_ready; t_wr records the capturing edge
  task automatic write_beat(input logic [7:0] d, input logic l);
    int t = 0;
    @(negedge s_clk);
    while (!bus.s_ready && t < 300) begin
      @(negedge s_clk);
      t++;
    end
    if (!bus.s_ready) begin
      note_fail("write_beat", "s_ready never rose");
    end else begin
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      exp_q.push_back({l, d});
      @(posedge s_clk);
      t_wr = $realtime;
      @(negedge s_clk);
      bus.s_valid = 1'b0;
    end
  endtask

  // random producer; packets kept to <= 4 beats and the final beat always closes a packet
  task automatic drive(input int n, input int pct);
    int   sent = 0;
    int   pkt_len = 0;
    int   t = 0;
    logic hold = 1'b0;
    while (sent < n && t < n * 60 + 200) begin
      @(negedge s_clk);
      t++;
      if (!hold) begin
        if ($urandom_range(99) < pct) begin
          bus.s_valid = 1'b1;
          bus.s_data  = 8'($urandom);
          bus.s_last  = (pkt_len == 3) || ($urandom_range(3) == 0) || (sent == n - 1);
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      check("full_vs_load", 32'(bus.s_ready), 32'(bus.s_load != (DB+1)'(DEPTH)));
      check("af_vs_load", 32'(bus.s_almost_full), 32'((DEPTH - int'(bus.s_load)) <= AF));
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({bus.s_last, bus.s_data});
        pkt_len = bus.s_last ? 0 : pkt_len + 1;
        sent++;
        hold = 1'b0;
      end else begin
        hold = bus.s_valid;
      end
    end
    if (sent < n) note_fail("drive", "producer budget expired");
    @(negedge s_clk);
    bus.s_valid = 1'b0;
  endtask

  // random consumer checking order, last flags and AXI-S stability
  task automatic monitor(input int target, input int pct);
    int         t = 0;
    int         budget = (target - rx_cnt) * 30 + 200;
    logic       held = 1'b0;
    logic [8:0] held_val = '0;
    while (rx_cnt < target && t < budget) begin
      @(negedge m_clk);
      t++;
      if (held) begin
        check("hold_valid", 32'(bus.m_valid), 32'(1));
        check("hold_data", 32'({bus.m_last, bus.m_data}), 32'(held_val));
      end
      bus.m_ready = ($urandom_range(99) < pct);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          note_fail("dup", "beat delivered with none pending");
        end else begin
          check("order", 32'({bus.m_last, bus.m_data}), 32'(exp_q.pop_front()));
        end
        rx_cnt++;
        held = 1'b0;
      end else begin
        held     = bus.m_valid;
        held_val = {bus.m_last, bus.m_data};
      end
    end
    if (rx_cnt < target) note_fail("monitor", "consumer budget expired");
    @(negedge m_clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic run_traffic(input int n, input int s_pct, input int m_pct);
    int target = rx_cnt + exp_q.size() + n;
    fork
      drive(n, s_pct);
      monitor(target, m_pct);
    join
  endtask

  initial begin
    realtime t_lim;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // ---- reset
    repeat (3) @(negedge m_clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'(0));
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    repeat (8) @(negedge m_clk);
    @(negedge s_clk) s_rst = 1'b0;
    @(negedge m_clk) m_rst = 1'b0;
    repeat (2) @(negedge s_clk);
    check("rel_s_ready", 32'(bus.s_ready), 32'(1));
    check("rel_s_load", 32'(bus.s_load), 32'(0));
    check("rel_s_af", 32'(bus.s_almost_full), 32'(0));
    @(negedge m_clk);
    check("rel_m_valid", 32'(bus.m_valid), 32'(0));
    check("rel_m_load", 32'(bus.m_load), 32'(0));
    check("rel_m_data", 32'(bus.m_data), 32'(0));
    check("rel_m_last", 32'(bus.m_last), 32'(0));

    // ---- fill to full with the reader stalled (100 MHz / 37 MHz)
    for (int i = 0; i < DEPTH; i++) begin
      fill_tab[i] = '{data: 8'(i), last: (i == DEPTH - 1), exp_load: i + 1,
                      exp_af: ((i + 1) >= DEPTH - AF), exp_rdy: (i < DEPTH - 1)};
    end
    for (int i = 0; i < DEPTH; i++) begin
      write_beat(fill_tab[i].data, fill_tab[i].last);
      check("fill_load", 32'(bus.s_load), 32'(fill_tab[i].exp_load));
      check("fill_af", 32'(bus.s_almost_full), 32'(fill_tab[i].exp_af));
      check("fill_rdy", 32'(bus.s_ready), 32'(fill_tab[i].exp_rdy));
    end
    repeat (5) @(negedge s_clk);
    check("full_holds", 32'(bus.s_ready), 32'(0));
    repeat (SYNC + 4) @(negedge m_clk);
    check("fill_m_valid", 32'(bus.m_valid), 32'(1));
    check("fill_m_data", 32'(bus.m_data), 32'(0));
    check("fill_m_load", 32'(bus.m_load), 32'(DEPTH));
    run_traffic(0, 0, 100);
    repeat (10) @(negedge s_clk);
    check("drain_s_load", 32'(bus.s_load), 32'(0));
    check("drain_s_ready", 32'(bus.s_ready), 32'(1));

    // ---- single beat latency into an empty FIFO
    @(negedge m_clk) bus.m_ready = 1'b1;
    write_beat(8'hA5, 1'b1);
    t_lim = t_wr + 2.0 * s_half + (SYNC + 2) * 2.0 * m_half + m_half;
    do @(negedge m_clk); while (!bus.m_valid && $realtime < t_lim + 6.0 * m_half);
    if (!bus.m_valid) begin
      note_fail("single_valid", "m_valid never rose");
    end else begin
      check("single_lat_max", 32'($realtime <= t_lim), 32'(1));
      check("single_lat_min", 32'($realtime >= t_wr + 2.0 * s_half + SYNC * 2.0 * m_half), 32'(1));
      check("single_data", 32'(bus.m_data), 32'(8'hA5));
      check("single_last", 32'(bus.m_last), 32'(1));
      void'(exp_q.pop_front());
      rx_cnt++;
    end
    @(negedge m_clk);
    check("single_m_valid", 32'(bus.m_valid), 32'(0));
    check("single_m_load", 32'(bus.m_load), 32'(0));
    bus.m_ready = 1'b0;

    // ---- three-beat packet with gaps: visible per beat, or only once committed in packet mode
    write_beat(8'h11, 1'b0);
    repeat (20) @(negedge s_clk);
    @(negedge m_clk);
`ifdef AXIS_ASYNC_FIFO_PKT_EN
    check("pkt_b1_valid", 32'(bus.m_valid), 32'(0));
`else
    check("pkt_b1_valid", 32'(bus.m_valid), 32'(1));
`endif
    write_beat(8'h22, 1'b0);
    repeat (20) @(negedge s_clk);
    @(negedge m_clk);
`ifdef AXIS_ASYNC_FIFO_PKT_EN
    check("pkt_b2_valid", 32'(bus.m_valid), 32'(0));
    check("pkt_b2_load", 32'(bus.m_load), 32'(0));
`else
    check("pkt_b2_valid", 32'(bus.m_valid), 32'(1));
    check("pkt_b2_load", 32'(bus.m_load), 32'(2));
`endif
    write_beat(8'h33, 1'b1);
    repeat (8) @(negedge m_clk);
    check("pkt_b3_valid", 32'(bus.m_valid), 32'(1));
    check("pkt_b3_data", 32'(bus.m_data), 32'(8'h11));
    check("pkt_b3_load", 32'(bus.m_load), 32'(3));
    run_traffic(0, 0, 100);

    // ---- pointer wrap at equal clocks, then exact full from a wrapped offset
    s_half = 5.0;
    m_half = 5.0;
    repeat (4) @(negedge s_clk);
    run_traffic(3 * DEPTH + 5, 100, 100);
    repeat (10) @(negedge s_clk);
    check("wrap_s_load", 32'(bus.s_load), 32'(0));
    check("wrap_s_ready", 32'(bus.s_ready), 32'(1));
    check("wrap_s_af", 32'(bus.s_almost_full), 32'(0));
    @(negedge m_clk);
    check("wrap_m_valid", 32'(bus.m_valid), 32'(0));
    check("wrap_m_load", 32'(bus.m_load), 32'(0));
    for (int i = 0; i < DEPTH; i++) begin
      write_beat(8'(8'hC0 + i), (i == DEPTH - 1));
    end
    check("wrap_full_rdy", 32'(bus.s_ready), 32'(0));
    check("wrap_full_load", 32'(bus.s_load), 32'(DEPTH));
    check("wrap_full_af", 32'(bus.s_almost_full), 32'(1));
    repeat (10) @(negedge s_clk);
    check("wrap_full_holds", 32'(bus.s_ready), 32'(0));
    repeat (8) @(negedge m_clk);
    check("wrap_full_m_load", 32'(bus.m_load), 32'(DEPTH));
    run_traffic(0, 0, 100);

    // ---- random traffic at 3:1 and 1:3 clock ratios
    s_half = 5.0;
    m_half = 15.0;
    repeat (4) @(negedge m_clk);
    run_traffic(2500, 70, 50);
    s_half = 15.0;
    m_half = 5.0;
    repeat (4) @(negedge s_clk);
    run_traffic(2500, 50, 70);
    check("model_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
